// File: rtl/write_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : write_buffer
// Purpose  : Packs 32-bit ALU result pixels four to a 128-bit beat, queues the
//            beats in a small FIFO and writes them to the DDR3 controller as
//            an Avalon-MM master (burst length 1, one address per beat).
// Ports    : iCLK / iRST_N (async, active low)
//            start, start_address, num_beats -> transfer request (when ready)
//            ready, done                     -> idle flag / completion pulse
//            pix_valid, pix_data, pix_ready  -> ALU pixel stream
//            local_init_done                 -> DDR3 calibration complete
//            avl_address, avl_write, avl_writedata, avl_burstbegin,
//            avl_wait_request_n              -> Avalon-MM write master
// Config   : WRITE_BUFFER_CLAMP_EN - when defined, negative pixels are
//            replaced by zero before packing (ReLU on write-back).
// Revision : 1.0 - initial release
// ============================================================================
module write_buffer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int ADDR_WIDTH  = 25,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_address,
    input  logic [COUNT_WIDTH-1:0] num_beats,
    output logic                   ready,
    output logic                   done,
    input  logic                   pix_valid,
    input  logic [31:0]            pix_data,
    output logic                   pix_ready,
    input  logic                   local_init_done,
    output logic [ADDR_WIDTH-1:0]  avl_address,
    output logic                   avl_write,
    output logic [127:0]           avl_writedata,
    output logic                   avl_burstbegin,
    input  logic                   avl_wait_request_n
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_PTR_W-1:0]     c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0]     c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]     c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0]  c_ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] c_BEAT_ONE = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH+1:0] c_PIX_ONE  = (COUNT_WIDTH+2)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Transfer bookkeeping
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [COUNT_WIDTH-1:0] r_num_beats;
    logic [COUNT_WIDTH-1:0] r_beats_written;
    logic [COUNT_WIDTH+1:0] r_pix_cnt;

    // Packer: lanes 0..2 are held here; lane 3 goes straight into the FIFO
    logic [1:0]  r_lane;
    logic [95:0] r_pack;

    // Beat FIFO
    logic [127:0]       r_fifo_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_fifo_cnt;

    // Registered Avalon request
    logic         r_avl_write;
    logic [127:0] r_avl_writedata;

    logic [31:0]        w_pix;
    logic               w_fifo_full;
    logic               w_start_acc;
    logic               w_pix_acc;
    logic               w_push;
    logic [127:0]       w_push_word;
    logic               w_accept;
    logic               w_last_beat;
    logic               w_more;
    logic [c_PTR_W-1:0] w_rd_ptr_inc;
    logic [127:0]       w_next_head;

`ifdef WRITE_BUFFER_CLAMP_EN
    assign w_pix = pix_data[31] ? 32'h0 : pix_data;
`else
    assign w_pix = pix_data;
`endif

    assign w_fifo_full  = (r_fifo_cnt == c_CNT_FULL);
    assign w_start_acc  = start & ready;
    assign w_pix_acc    = pix_valid & pix_ready;
    assign w_push       = w_pix_acc & (r_lane == 2'd3);
    assign w_push_word  = {w_pix, r_pack};
    assign w_accept     = r_avl_write & avl_wait_request_n;
    assign w_last_beat  = w_accept & (r_beats_written == (r_num_beats - c_BEAT_ONE));
    assign w_rd_ptr_inc = r_rd_ptr + c_PTR_ONE;

    // After a pop the new head is either the next stored entry or, when the
    // FIFO held only the beat being accepted, the word being pushed on this
    // very edge (forwarded so back-to-back issue does not lose a cycle).
    assign w_more      = local_init_done &
                         ((r_fifo_cnt > c_CNT_ONE) | ((r_fifo_cnt == c_CNT_ONE) & w_push));
    assign w_next_head = (r_fifo_cnt > c_CNT_ONE) ? r_fifo_mem[w_rd_ptr_inc] : w_push_word;

    assign avl_address    = r_addr;
    assign avl_write      = r_avl_write;
    assign avl_writedata  = r_avl_writedata;
    assign avl_burstbegin = r_avl_write;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        done        = 1'b0;
        pix_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_nxt = (num_beats == '0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                // The fourth lane needs a free FIFO slot; lanes 0..2 only
                // fill the packing register and never stall.
                pix_ready = (r_pix_cnt < {r_num_beats, 2'b00}) &
                            !((r_lane == 2'd3) & w_fifo_full);
                if (w_last_beat) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                ready       = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
                if (start) begin
                    w_state_nxt = (num_beats == '0) ? S_FINISH : S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transfer counters, packer, FIFO pointers and Avalon request
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_addr          <= '0;
            r_num_beats     <= '0;
            r_beats_written <= '0;
            r_pix_cnt       <= '0;
            r_lane          <= 2'd0;
            r_pack          <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_fifo_cnt      <= '0;
            r_avl_write     <= 1'b0;
            r_avl_writedata <= '0;
        end else begin
            if (w_start_acc) begin
                r_addr          <= start_address;
                r_num_beats     <= num_beats;
                r_beats_written <= '0;
                r_pix_cnt       <= '0;
                r_lane          <= 2'd0;
            end else begin
                if (w_pix_acc) begin
                    r_pix_cnt <= r_pix_cnt + c_PIX_ONE;
                    r_lane    <= r_lane + 2'd1;
                    case (r_lane)
                        2'd0:    r_pack[31:0]  <= w_pix;
                        2'd1:    r_pack[63:32] <= w_pix;
                        2'd2:    r_pack[95:64] <= w_pix;
                        default: ;
                    endcase
                end
                if (w_accept) begin
                    r_addr          <= r_addr + c_ADDR_ONE;
                    r_beats_written <= r_beats_written + c_BEAT_ONE;
                end
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_accept) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            case ({w_push, w_accept})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + c_CNT_ONE;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - c_CNT_ONE;
                default: ;
            endcase

            // A pending request is held until accepted; new requests are
            // only launched once the controller has finished calibration.
            if (w_accept) begin
                r_avl_write <= w_more;
                if (w_more) begin
                    r_avl_writedata <= w_next_head;
                end
            end else if (!r_avl_write && (r_fifo_cnt != '0) && local_init_done) begin
                r_avl_write     <= 1'b1;
                r_avl_writedata <= r_fifo_mem[r_rd_ptr];
            end
        end
    end

    // FIFO storage (no reset needed; occupancy is tracked by r_fifo_cnt)
    always_ff @(posedge iCLK) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= w_push_word;
        end
    end

endmodule
`default_nettype wire
